// File: rtl/shift_add_pkg.sv
// ----------------------------------------------------------------------------
// shift_add_pkg
//   Shared types for the shift-add multiplier controller.
//   - state_t : 3-bit FSM state encoding, IDLE = 0 so a cleared register is idle
//   - cnt_w() : width of the iteration counter for a given operand width
// ----------------------------------------------------------------------------
package shift_add_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/shift_add_cnt.sv
// ----------------------------------------------------------------------------
// shift_add_cnt
//   Iteration counter for the shift-add controller. Counts completed shifts
//   and wraps to 0 on the final one so it rests at 0 outside an operation.
//   Ports:
//     Clk, Rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear (operand load)
//     inc        : one shift completes this cycle
//     count      : number of completed shifts
//     last       : count is at WIDTH-1 (the current shift is the final one)
// ----------------------------------------------------------------------------
module shift_add_cnt
    import shift_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    assign last = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            // Explicit wrap: WIDTH need not be a power of two.
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_add_ctrl.sv
// ----------------------------------------------------------------------------
// shift_add_ctrl
//   Control FSM for a WIDTH-bit add/shift multiplier:
//   IDLE -> LOAD -> (EVAL -> SHIFT) x WIDTH -> DONE -> IDLE.
//   Idle/Load/Sh/Done are registered Moore outputs; Ad is Mealy (M in EVAL).
//   Ports:
//     Clk, Rst_n : clock, asynchronous active-low reset
//     St         : start level, sampled only in IDLE
//     M          : current multiplier LSB from the datapath
//     Ack        : result acknowledge (only with the ack option below)
//     Idle, Load, Ad, Sh, Done : datapath controls / status
//     Count      : number of completed shifts
//   Option macro SHIFT_ADD_CTRL_DONE_ACK_EN: DONE holds until Ack is sampled
//   high. Without it DONE lasts one cycle and Ack is ignored.
// ----------------------------------------------------------------------------
module shift_add_ctrl
    import shift_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             St,
    input  logic             M,
    input  logic             Ack,
    output logic             Idle,
    output logic             Load,
    output logic             Ad,
    output logic             Sh,
    output logic             Done,
    output logic [CNT_W-1:0] Count
);

    state_t state;
    logic   cnt_last;

`ifndef SHIFT_ADD_CTRL_DONE_ACK_EN
    // Port kept for interface compatibility; nothing consumes it.
    logic unused_ack;
    assign unused_ack = Ack;
`endif

    // Registered Load/Sh are high exactly in LOAD/SHIFT, so they double as
    // the counter's clear and increment.
    shift_add_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clr   (Load),
        .inc   (Sh),
        .count (Count),
        .last  (cnt_last)
    );

    // Mealy add: follows M combinationally, only while evaluating.
    assign Ad = (state == EVAL) && M;

    // Each arm updates the Moore outputs together with the state, so they
    // always reflect the state they are registered alongside.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            Idle  <= 1'b1;
            Load  <= 1'b0;
            Sh    <= 1'b0;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (St) begin
                        state <= LOAD;
                        Idle  <= 1'b0;
                        Load  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= EVAL;
                    Load  <= 1'b0;
                end
                EVAL: begin
                    state <= SHIFT;
                    Sh    <= 1'b1;
                end
                SHIFT: begin
                    Sh <= 1'b0;
                    if (cnt_last) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else begin
                        state <= EVAL;
                    end
                end
                DONE: begin
`ifdef SHIFT_ADD_CTRL_DONE_ACK_EN
                    if (Ack) begin
                        state <= IDLE;
                        Done  <= 1'b0;
                        Idle  <= 1'b1;
                    end
`else
                    state <= IDLE;
                    Done  <= 1'b0;
                    Idle  <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                    Idle  <= 1'b1;
                    Load  <= 1'b0;
                    Sh    <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_shift_add_ctrl
//   Four controllers (WIDTH = 2, 4, 8, 16) share the same stimulus. Each cycle
//   the expected outputs of every instance are derived from the operation
//   timeline, queued, then popped and compared against the instance.
// ----------------------------------------------------------------------------
module tb_shift_add_ctrl;

    localparam int NW = 4;

    logic Clk, Rst_n, St, M, Ack;
    logic [NW-1:0] idle, load, ad, sh, done;
    logic [0:0] c2;
    logic [1:0] c4;
    logic [2:0] c8;
    logic [3:0] c16;
    logic [3:0] cnt [NW];

    assign cnt[0] = 4'(c2);
    assign cnt[1] = 4'(c4);
    assign cnt[2] = 4'(c8);
    assign cnt[3] = c16;

    shift_add_ctrl #(.WIDTH(2)) u_w2 (
        .Clk(Clk), .Rst_n(Rst_n), .St(St), .M(M), .Ack(Ack),
        .Idle(idle[0]), .Load(load[0]), .Ad(ad[0]), .Sh(sh[0]), .Done(done[0]), .Count(c2));
    shift_add_ctrl #(.WIDTH(4)) u_w4 (
        .Clk(Clk), .Rst_n(Rst_n), .St(St), .M(M), .Ack(Ack),
        .Idle(idle[1]), .Load(load[1]), .Ad(ad[1]), .Sh(sh[1]), .Done(done[1]), .Count(c4));
    shift_add_ctrl #(.WIDTH(8)) u_w8 (
        .Clk(Clk), .Rst_n(Rst_n), .St(St), .M(M), .Ack(Ack),
        .Idle(idle[2]), .Load(load[2]), .Ad(ad[2]), .Sh(sh[2]), .Done(done[2]), .Count(c8));
    shift_add_ctrl #(.WIDTH(16)) u_w16 (
        .Clk(Clk), .Rst_n(Rst_n), .St(St), .M(M), .Ack(Ack),
        .Idle(idle[3]), .Load(load[3]), .Ad(ad[3]), .Sh(sh[3]), .Done(done[3]), .Count(c16));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic idle, load, ad, sh, done;
        int   count;
    } exp_t;

    // mmode: 0 all zeros, 1 all ones, 2 random, 3 M high when k%4==1
    typedef struct {
        int mmode;
        bit hold;
        int ncyc;
        int d2, d4, d8, d16;   // edge index at which DONE is entered
        int ad4;               // Ad cycles on WIDTH=4 in one operation (-1 skip)
        int sh4;               // Sh cycles on WIDTH=4 in one operation
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    vec_t vecs[5];

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    function automatic int de_of(input vec_t v, input int i);
        case (i)
            0:       return v.d2;
            1:       return v.d4;
            2:       return v.d8;
            default: return v.d16;
        endcase
    endfunction

    function automatic logic m_of(input int mode, input int k);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return (k % 4 == 1);
        endcase
    endfunction

    function automatic logic ack_val();
`ifdef SHIFT_ADD_CTRL_DONE_ACK_EN
        return 1'b1;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    // Expected outputs k edges after St was sampled (k=0: just entered LOAD).
    function automatic exp_t expect_at(input int de, input int k, input logic m,
                                       input bit hold);
        exp_t e;
        int   p;
        e = '{idle: 1'b0, load: 1'b0, ad: 1'b0, sh: 1'b0, done: 1'b0, count: 0};
        p = hold ? (k % (de + 2)) : k;
        if (p == 0)       e.load = 1'b1;
        else if (p < de) begin
            if (p % 2 == 1) begin e.ad = m;    e.count = (p - 1) / 2; end
            else            begin e.sh = 1'b1; e.count = (p - 2) / 2; end
        end
        else if (p == de) e.done = 1'b1;
        else              e.idle = 1'b1;
        return e;
    endfunction

    task automatic cmp_all();
        exp_t e;
        for (int i = 0; i < NW; i++) begin
            e = sb_q.pop_front();
            chk("idle",  i, 32'(idle[i]), 32'(e.idle));
            chk("load",  i, 32'(load[i]), 32'(e.load));
            chk("ad",    i, 32'(ad[i]),   32'(e.ad));
            chk("sh",    i, 32'(sh[i]),   32'(e.sh));
            chk("done",  i, 32'(done[i]), 32'(e.done));
            chk("count", i, 32'(cnt[i]),  32'(e.count));
            chk("onehot", i, 32'($countones({load[i], ad[i], sh[i], done[i]}) <= 1), 32'd1);
        end
    endtask

    task automatic reset_chk(input string nm);
        for (int i = 0; i < NW; i++) begin
            chk({nm, "_idle"},  i, 32'(idle[i]), 32'd1);
            chk({nm, "_load"},  i, 32'(load[i]), 32'd0);
            chk({nm, "_ad"},    i, 32'(ad[i]),   32'd0);
            chk({nm, "_sh"},    i, 32'(sh[i]),   32'd0);
            chk({nm, "_done"},  i, 32'(done[i]), 32'd0);
            chk({nm, "_count"}, i, 32'(cnt[i]),  32'd0);
        end
    endtask

    // Asynchronous reset pulse between clock edges; checked before any edge.
    task automatic reset_pulse(input string nm);
        St = 1'b0;
        Rst_n = 1'b0;
        #1;
        reset_chk(nm);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   n_ad4 = 0;
        int   n_sh4 = 0;
        exp_t e;
        St = 1'b1;
        for (int k = 0; k < v.ncyc; k++) begin
            @(negedge Clk);
            if (!v.hold) St = 1'b0;
            M   = m_of(v.mmode, k);
            Ack = ack_val();
            for (int i = 0; i < NW; i++) begin
                e = expect_at(de_of(v, i), k, M, v.hold);
                sb_q.push_back(e);
            end
            #1;
            if (k < v.d4) begin
                n_ad4 += int'(ad[1]);
                n_sh4 += int'(sh[1]);
            end
            cmp_all();
        end
        if (v.ad4 >= 0) chk("ad_cycles_w4", 1, 32'(n_ad4), 32'(v.ad4));
        chk("sh_cycles_w4", 1, 32'(n_sh4), 32'(v.sh4));
        reset_pulse("post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        Rst_n = 1'b1; St = 1'b0; M = 1'b0; Ack = 1'b0;

        vecs[0] = '{mmode: 1, hold: 1'b0, ncyc: 36, d2: 5, d4: 9, d8: 17, d16: 33, ad4: 4,  sh4: 4};
        vecs[1] = '{mmode: 0, hold: 1'b0, ncyc: 36, d2: 5, d4: 9, d8: 17, d16: 33, ad4: 0,  sh4: 4};
        vecs[2] = '{mmode: 2, hold: 1'b0, ncyc: 36, d2: 5, d4: 9, d8: 17, d16: 33, ad4: -1, sh4: 4};
        vecs[3] = '{mmode: 3, hold: 1'b0, ncyc: 36, d2: 5, d4: 9, d8: 17, d16: 33, ad4: 2,  sh4: 4};
        vecs[4] = '{mmode: 1, hold: 1'b1, ncyc: 45, d2: 5, d4: 9, d8: 17, d16: 33, ad4: 4,  sh4: 4};

        // Power-on reset, checked with no clock edge seen.
        #2 Rst_n = 1'b0;
        #1 reset_chk("por");
        #1 Rst_n = 1'b1;
        // St low: the first edge after reset keeps every instance idle.
        @(negedge Clk); #1;
        for (int i = 0; i < NW; i++) chk("idle_no_st", i, 32'(idle[i]), 32'd1);

        foreach (vecs[v]) run_vec(vecs[v]);

        // Reset during SHIFT with Count=2 on WIDTH=4 (k=6).
        St = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge Clk);
            St = 1'b0;
            M  = 1'b1;
        end
        #1;
        chk("mid_sh_w4",    1, 32'(sh[1]),  32'd1);
        chk("mid_count_w4", 1, 32'(cnt[1]), 32'd2);
        reset_pulse("mid_reset");
        // After release: St low -> stays idle, then St high -> LOAD next edge.
        @(negedge Clk); #1;
        chk("rel_idle", 1, 32'(idle[1]), 32'd1);
        St = 1'b1;
        @(negedge Clk);
        St = 1'b0;
        #1;
        chk("rel_load", 1, 32'(load[1]), 32'd1);
        chk("rel_cnt",  1, 32'(cnt[1]),  32'd0);
        reset_pulse("rel_reset");

`ifdef SHIFT_ADD_CTRL_DONE_ACK_EN
        // Ack mode on WIDTH=4: Ack pulse in EVAL ignored, DONE held 6 cycles.
        n_done = 0;
        Ack = 1'b0;
        St  = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            @(negedge Clk);
            St  = 1'b0;
            M   = 1'b1;
            Ack = (k == 1) || (k >= 14);
            #1;
            if (k == 2)  chk("ack_eval_ignored", 1, 32'(sh[1]), 32'd1);
            if (k == 9)  chk("ack_done_enter",   1, 32'(done[1]), 32'd1);
            if (k == 15) chk("ack_idle_after",   1, 32'(idle[1]), 32'd1);
            n_done += int'(done[1]);
        end
        chk("ack_done_cycles", 1, 32'(n_done), 32'd6);
        reset_pulse("ack_reset");
`else
        // Ack held low: DONE still lasts exactly one cycle on WIDTH=4.
        n_done = 0;
        Ack = 1'b0;
        St  = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge Clk);
            St  = 1'b0;
            Ack = 1'b0;
            #1;
            n_done += int'(done[1]);
            if (k == 10) chk("noack_idle", 1, 32'(idle[1]), 32'd1);
        end
        chk("noack_done_cycles", 1, 32'(n_done), 32'd1);
        reset_pulse("noack_reset");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
